// File: rtl/pmu_counter_bank.sv
// PMU event counter bank: one counter lane per event input, plus a capture stage and a sticky, maskable overflow interrupt.
// Optional macro PMU_COUNTER_SATURATE_EN makes counters saturate at all-ones instead of wrapping.

module pmu_ctr_lane #(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 ev_i,
  input  logic                 wr_i,
  input  logic [REG_WIDTH-1:0] wr_data_i,
  input  logic                 ovf_clr_i,
  output logic [REG_WIDTH-1:0] cnt_o,
  output logic                 ovf_o
);
  localparam logic [REG_WIDTH-1:0] ONE  = {{(REG_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [REG_WIDTH-1:0] ONES = {REG_WIDTH{1'b1}};

  logic [REG_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 wrap;

  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (wr_i) begin
      cnt_d = wr_data_i;
    end else if (ev_i) begin
`ifdef PMU_COUNTER_SATURATE_EN
      if (cnt_q != ONES) begin
        cnt_d = cnt_q + ONE;
        wrap  = (cnt_d == ONES);
      end
`else
      cnt_d = cnt_q + ONE;
      wrap  = (cnt_q == ONES);
`endif
    end
    // a wrap in the same cycle as a clear keeps the flag set
    ovf_d = (ovf_q & ~ovf_clr_i) | wrap;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;
endmodule

module pmu_counter_bank #(
  parameter  int REG_WIDTH  = 32,
  parameter  int N_COUNTERS = 9,
  localparam int IDX_W      = $clog2(N_COUNTERS)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  softrst_i,
  input  logic                                  en_i,
  input  logic [N_COUNTERS-1:0]                 events_i,
  input  logic                                  we_i,
  input  logic [IDX_W-1:0]                      wr_idx_i,
  input  logic [REG_WIDTH-1:0]                  wr_data_i,
  input  logic [N_COUNTERS-1:0]                 ovf_mask_i,
  input  logic [N_COUNTERS-1:0]                 ovf_clr_i,
  output logic [N_COUNTERS-1:0][REG_WIDTH-1:0]  counter_value_o,
  output logic [N_COUNTERS-1:0]                 ovf_status_o,
  output logic                                  intr_overflow_o
);
  logic                  srst;
  logic [N_COUNTERS-1:0] ev_q, ev_d;
  logic                  intr_q, intr_d;

  assign srst   = rst_i | softrst_i;
  // enable is sampled together with the event, not at increment time
  assign ev_d   = events_i & {N_COUNTERS{en_i}};
  assign intr_d = |(ovf_status_o & ovf_mask_i);

  always_ff @(posedge clk_i) begin
    if (srst) begin
      ev_q   <= '0;
      intr_q <= 1'b0;
    end else begin
      ev_q   <= ev_d;
      intr_q <= intr_d;
    end
  end

  // out-of-range write indices match no lane and are dropped
  for (genvar k = 0; k < N_COUNTERS; k++) begin : g_lane
    pmu_ctr_lane #(.REG_WIDTH(REG_WIDTH)) u_lane (
      .clk_i     (clk_i),
      .srst_i    (srst),
      .ev_i      (ev_q[k]),
      .wr_i      (we_i && (wr_idx_i == IDX_W'(k))),
      .wr_data_i (wr_data_i),
      .ovf_clr_i (ovf_clr_i[k]),
      .cnt_o     (counter_value_o[k]),
      .ovf_o     (ovf_status_o[k])
    );
  end

  assign intr_overflow_o = intr_q;
endmodule

// File: tb/tb_pmu_counter_bank.sv
// Scoreboard bench for pmu_counter_bank: reference model pushes expected state per cycle, popped after each edge.
module tb_pmu_counter_bank;
  localparam int W  = 32;
  localparam int N  = 9;
  localparam int IW = $clog2(N);
  localparam int CW = N * W;
`ifdef PMU_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_i, softrst_i, en_i, we_i;
  logic [N-1:0]         events_i, ovf_mask_i, ovf_clr_i;
  logic [IW-1:0]        wr_idx_i;
  logic [W-1:0]         wr_data_i;
  logic [N-1:0][W-1:0]  counter_value_o;
  logic [N-1:0]         ovf_status_o;
  logic                 intr_overflow_o;

  pmu_counter_bank #(.REG_WIDTH(W), .N_COUNTERS(N)) dut (
    .clk_i(clk), .rst_i(rst_i), .softrst_i(softrst_i), .en_i(en_i),
    .events_i(events_i), .we_i(we_i), .wr_idx_i(wr_idx_i), .wr_data_i(wr_data_i),
    .ovf_mask_i(ovf_mask_i), .ovf_clr_i(ovf_clr_i),
    .counter_value_o(counter_value_o), .ovf_status_o(ovf_status_o),
    .intr_overflow_o(intr_overflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [CW-1:0] cnt;
    logic [N-1:0]  st;
    logic          intr;
  } exp_t;
  exp_t sbq[$];

  logic [W-1:0] m_cnt [N];
  logic [N-1:0] m_ev, m_st;
  logic         m_intr;

  function automatic logic [CW-1:0] pack_m();
    logic [CW-1:0] p;
    for (int k = 0; k < N; k++) p[k*W +: W] = m_cnt[k];
    return p;
  endfunction

  // reference model: state after the coming edge, from currently driven inputs
  task automatic model_step();
    logic [N-1:0] nst;
    if (rst_i || softrst_i) begin
      for (int k = 0; k < N; k++) m_cnt[k] = '0;
      m_ev = '0; m_st = '0; m_intr = 1'b0;
    end else begin
      nst    = m_st & ~ovf_clr_i;
      m_intr = |(m_st & ovf_mask_i);
      for (int k = 0; k < N; k++) begin
        if (we_i && int'(wr_idx_i) == k) m_cnt[k] = wr_data_i;
        else if (m_ev[k]) begin
          if (SAT) begin
            if (m_cnt[k] != {W{1'b1}}) begin
              m_cnt[k] = m_cnt[k] + 1;
              if (m_cnt[k] == {W{1'b1}}) nst[k] = 1'b1;
            end
          end else begin
            if (m_cnt[k] == {W{1'b1}}) nst[k] = 1'b1;
            m_cnt[k] = m_cnt[k] + 1;
          end
        end
      end
      m_st = nst;
      m_ev = events_i & {N{en_i}};
    end
  endtask

  task automatic tick(input string tag, input logic [N-1:0] ev, input logic w,
                      input logic [IW-1:0] idx, input logic [W-1:0] d,
                      input logic [N-1:0] clr, input logic sr);
    exp_t e;
    events_i = ev; we_i = w; wr_idx_i = idx; wr_data_i = d; ovf_clr_i = clr; softrst_i = sr;
    model_step();
    e.cnt = pack_m(); e.st = m_st; e.intr = m_intr;
    sbq.push_back(e);
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk({tag, "_cnt"}, counter_value_o, e.cnt);
    chk({tag, "_st"}, ovf_status_o, e.st);
    chk({tag, "_intr"}, intr_overflow_o, e.intr);
    events_i = '0; we_i = 1'b0; wr_idx_i = '0; wr_data_i = '0; ovf_clr_i = '0; softrst_i = 1'b0;
  endtask

  task automatic idle(input string tag);
    tick(tag, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic wr(input string tag, input int idx, input logic [W-1:0] d);
    tick(tag, '0, 1'b1, IW'(idx), d, '0, 1'b0);
  endtask

  localparam logic [W-1:0] OVF_SEED = SAT ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;

  initial begin
    rst_i = 1'b1; softrst_i = 1'b0; en_i = 1'b0; we_i = 1'b0; events_i = '0;
    wr_idx_i = '0; wr_data_i = '0; ovf_mask_i = '0; ovf_clr_i = '0;
    for (int k = 0; k < N; k++) m_cnt[k] = 'x;
    m_ev = 'x; m_st = 'x; m_intr = 1'bx;
    idle("rst0");
    idle("rst1");
    chk("rst_cnt", counter_value_o, '0);
    chk("rst_st", ovf_status_o, '0);
    chk("rst_intr", intr_overflow_o, 1'b0);
    rst_i = 1'b0;

    // basic count
    en_i = 1'b1;
    for (int i = 0; i < 5; i++) tick("cnt", N'(1), 1'b0, '0, '0, '0, 1'b0);
    chk("cnt0_lat", counter_value_o[0], 4);
    idle("cnt_i");
    chk("cnt0_eq5", counter_value_o[0], 5);
    chk("cnt_others", counter_value_o[N-1:1], '0);
    chk("cnt_intr", intr_overflow_o, 1'b0);

    // enable gating
    en_i = 1'b0;
    for (int i = 0; i < 10; i++) tick("gate_off", N'(1 << 3), 1'b0, '0, '0, '0, 1'b0);
    en_i = 1'b1;
    for (int i = 0; i < 3; i++) tick("gate_on", N'(1 << 3), 1'b0, '0, '0, '0, 1'b0);
    idle("gate_i");
    chk("gate_cnt3", counter_value_o[3], 3);

    // write priority over a captured event
    wr("wr7", 2, 7);
    chk("wr_vis", counter_value_o[2], 7);
    tick("wr_ev", N'(1 << 2), 1'b0, '0, '0, '0, 1'b0);
    wr("wr100", 2, 100);
    idle("wr_i");
    chk("wr_drop", counter_value_o[2], 100);
    wr("wr_oob", N, 32'h55);
    wr("wr_oob15", 15, 32'h66);
    chk("wr_oob_c2", counter_value_o[2], 100);
    chk("wr_oob_c0", counter_value_o[0], 5);

    // overflow and interrupt on counter 1
    ovf_mask_i = N'(1 << 1);
    wr("ovf_seed", 1, 32'hFFFF_FFFE);
    tick("ovf_ev0", N'(1 << 1), 1'b0, '0, '0, '0, 1'b0);
    tick("ovf_ev1", N'(1 << 1), 1'b0, '0, '0, '0, 1'b0);
    idle("ovf_i0");
    if (SAT) begin
      chk("sat_cnt1", counter_value_o[1], 32'hFFFF_FFFF);
      chk("sat_st1", ovf_status_o[1], 1'b1);
      chk("sat_intr", intr_overflow_o, 1'b1);
    end else begin
      chk("wrap_cnt1", counter_value_o[1], 0);
      chk("wrap_st1", ovf_status_o[1], 1'b1);
      chk("wrap_intr_lat", intr_overflow_o, 1'b0);
    end
    idle("ovf_i1");
    chk("ovf_intr", intr_overflow_o, 1'b1);
    tick("ovf_clr", '0, 1'b0, '0, '0, N'(1 << 1), 1'b0);
    chk("clr_st1", ovf_status_o[1], 1'b0);
    idle("clr_i");
    chk("clr_intr", intr_overflow_o, 1'b0);

    // wrap and clear on the same edge: set wins
    wr("sc_seed", 1, OVF_SEED);
    tick("sc_ev", N'(1 << 1), 1'b0, '0, '0, '0, 1'b0);
    tick("sc_clr", '0, 1'b0, '0, '0, N'(1 << 1), 1'b0);
    chk("sc_st1", ovf_status_o[1], 1'b1);
    tick("sc_clr2", '0, 1'b0, '0, '0, N'(1 << 1), 1'b0);
    idle("sc_i");

    // masked overflow on counter 4
    wr("msk_seed", 4, OVF_SEED);
    tick("msk_ev", N'(1 << 4), 1'b0, '0, '0, '0, 1'b0);
    idle("msk_i0");
    chk("msk_st4", ovf_status_o[4], 1'b1);
    idle("msk_i1");
    chk("msk_intr0", intr_overflow_o, 1'b0);
    ovf_mask_i = ovf_mask_i | N'(1 << 4);
    idle("msk_set");
    chk("msk_intr1", intr_overflow_o, 1'b1);

    // all counters at once, back to back, then soft reset with one event in flight
    tick("all0", '1, 1'b0, '0, '0, '0, 1'b0);
    tick("all1", '1, 1'b0, '0, '0, '0, 1'b0);
    tick("srst", '0, 1'b0, '0, '0, '0, 1'b1);
    chk("srst_cnt", counter_value_o, '0);
    chk("srst_st", ovf_status_o, '0);
    chk("srst_intr", intr_overflow_o, 1'b0);
    idle("srst_i0");
    idle("srst_i1");
    chk("srst_flight", counter_value_o, '0);

    // random traffic against the model
    ovf_mask_i = N'($urandom);
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] d;
      d = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFD + W'($urandom_range(0, 2)) : W'($urandom);
      en_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) ovf_mask_i = N'($urandom);
      tick("rnd", N'($urandom), ($urandom_range(0, 4) == 0), IW'($urandom_range(0, 15)), d,
           ($urandom_range(0, 3) == 0) ? N'($urandom) : '0, ($urandom_range(0, 60) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/pmu_counter_bank.md
Name: pmu_counter_bank

Overview:
- Bank of N_COUNTERS free-running event counters.
- Sits directly upstream of the PMU quota checker: its counter_value_o array drives that stage's per-counter value inputs.
- Counts single-cycle event pulses from the core/bus event crossbar, and accepts configuration writes (preload/clear) from the PMU register wrapper.
- Raises a maskable, sticky overflow interrupt.

Parameters:
- REG_WIDTH, 32, width of each counter.
- N_COUNTERS, 9, number of counters and of event inputs.
- IDX_W, $clog2(N_COUNTERS) (localparam), width of the write index.

Ports:
- clk_i  in  1  single clock, all state on posedge.
- rst_i  in  1  synchronous reset, active-high.
- softrst_i  in  1  soft reset from config registers, active-high, synchronous.
- en_i  in  1  global count enable.
- events_i  in  N_COUNTERS  event pulses, bit k feeds counter k.
- we_i  in  1  counter write strobe.
- wr_idx_i  in  IDX_W  counter index to write.
- wr_data_i  in  REG_WIDTH  value to load.
- ovf_mask_i  in  N_COUNTERS  overflow interrupt enable per counter.
- ovf_clr_i  in  N_COUNTERS  write-1-to-clear for overflow status bits.
- counter_value_o  out  REG_WIDTH x [0:N_COUNTERS-1]  current counter values, registered.
- ovf_status_o  out  N_COUNTERS  sticky overflow flags.
- intr_overflow_o  out  1  registered OR of (ovf_status & ovf_mask_i).

Behaviour:
- Reset: rst_i or softrst_i clears every counter, the event pipeline register, ovf_status_o and intr_overflow_o to 0 at the next edge. rst_i has priority. softrst_i alone has identical effect.
- Stage 1, event capture: at every edge, ev_q <= events_i & {N_COUNTERS{en_i}}.
  - en_i is sampled with the event, not at the increment.
- Stage 2, update per counter k at the next edge, in priority order:
  1. we_i && wr_idx_i==k: counter <= wr_data_i. A pending ev_q[k] is dropped. No overflow flag is set.
  2. Else if ev_q[k]: counter <= counter+1 (modulo 2^REG_WIDTH). On all-ones -> 0 wrap, set ovf_status[k].
  3. Else hold.
- Write index: a wr_idx_i >= N_COUNTERS is ignored (no counter changes).
- Latency:
  - Event pulse at edge t -> counter_value_o updated after edge t+1.
  - Write at edge t -> visible after edge t.
  - Wrap at edge t -> ovf_status_o set after edge t; intr_overflow_o high after edge t+1.
- Overflow status: ovf_status[k] <= (ovf_status[k] & ~ovf_clr_i[k]) | wrap[k]. Set wins over a same-cycle clear.
- Interrupt: intr_overflow_o <= |(ovf_status_o & ovf_mask_i).
  - Not sticky by itself.
  - Drops one cycle after status is cleared or the mask bit is cleared.
- Event spacing: back-to-back events on consecutive cycles each count (1 per cycle max per counter).
- Counter independence: counters are fully independent. Simultaneous events on all counters all count in the same cycle.
- Reset mid-operation: an event captured in ev_q when softrst_i is asserted is discarded.

Optional Feature:
- Macro: PMU_COUNTER_SATURATE_EN.
- Defined:
  - Counters saturate at all-ones instead of wrapping; a further event leaves the value unchanged.
  - ovf_status[k] is set on the edge where the counter transitions to all-ones.
  - Writes still override.
- Undefined: modulo wrap as described in Behaviour.

Test Plan:
- Reset/basic count: reset, en_i=1, pulse events_i[0] for 5 cycles -> counter_value_o[0]==5 two edges after last pulse; all other counters 0; intr_overflow_o=0.
- Enable gating: en_i=0, 10 pulses on events_i[3]; then en_i=1, 3 pulses -> counter 3 ==3.
- Write priority: counter 2 ==7 with an event captured; same cycle we_i=1, wr_idx_i=2, wr_data_i=100 -> counter 2 ==100; the event is dropped. wr_idx_i=N_COUNTERS -> no counter changes.
- Overflow and interrupt, wrap build:
  - Write counter 1 = 0xFFFF_FFFE, ovf_mask_i[1]=1, two events -> counter 1 ==0 after second increment.
  - ovf_status_o[1]=1 that edge; intr_overflow_o=1 one edge later.
  - Pulse ovf_clr_i[1] -> status 0, interrupt 0 next edge.
  - Same-cycle wrap+clear -> status stays 1.
  - Saturate build: counter 1 ends at 0xFFFF_FFFF; status set when it reaches all-ones.
- Mask: overflow counter 4 with ovf_mask_i[4]=0 -> ovf_status_o[4]=1, intr_overflow_o=0. Set the mask -> interrupt 1 next edge.
- Soft reset mid-count: counters nonzero, status set, events in flight, assert softrst_i one cycle -> all counters 0, status 0, interrupt 0 after that edge. The in-flight event does not appear afterwards.
